pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload bit width (1..256).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port flush  input  1  invalidates all stages at the next edge.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  last stage holds valid payload.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  last-stage payload, registered.
REQ-012 SHALL have port occ  output  3  count of valid stages, 0..DEPTH.
REQ-013 SHALL have port stall_cnt  output  16  output-stall cycle count (see Configuration).

Function
REQ-014 Each stage i SHALL hold v[i] and d[i]; stage DEPTH-1 drives out_valid/out_data directly from flops.
REQ-015 Stage i SHALL load from stage i-1 (stage 0 from in_*) when v[i]==0 or stage i advances this cycle; stage DEPTH-1 advances when out_ready==1.
REQ-016 in_ready SHALL equal (!v[0] or stage 0 advances) and !flush; transfer occurs on in_valid && in_ready.
REQ-017 Bubbles SHALL collapse: an empty stage accepts even if downstream is stalled.
REQ-018 Latency SHALL be DEPTH cycles from input transfer to out_valid with no backpressure; throughput one transfer per cycle.
REQ-019 Payload SHALL be unmodified; ordering SHALL be strictly FIFO; no word SHALL be duplicated or dropped except by flush.
REQ-020 When a stage does not load, its d[i] and v[i] SHALL hold.
REQ-021 On flush==1, all v[i] SHALL be 0 after the edge; d[i] SHALL hold; in_valid that cycle is dropped.
REQ-022 flush with out_valid && out_ready SHALL count as a completed output transfer.
REQ-023 occ SHALL be the registered population count of v[]; occ==DEPTH with !out_ready means full, in_ready==0.

Reset
REQ-024 reset==0 at a rising edge SHALL clear all v[i], all d[i] to 0, occ to 0, stall_cnt to 0.
REQ-025 Reset SHALL take priority over flush and all handshakes; in-flight data is discarded.
REQ-026 During reset, in_ready SHALL be 0 and out_valid SHALL be 0 from the first edge with reset low.

Configuration
REQ-027 Macro PIPE_STALL_CNT_EN SHALL control the stall counter.
REQ-028 With PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment once per cycle with out_valid && !out_ready, saturating at 16'hFFFF; flush SHALL NOT clear it.
REQ-029 Without PIPE_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL exist.

Verification (WIDTH=32, DEPTH=2)
REQ-030 Reset low 1 cycle, then in_valid=1, in_data=0xA5A5_0001 at cycle 0, out_ready=1 -> out_valid=1, out_data=0xA5A5_0001 at cycle 2; occ=1 at cycles 1 and 2.
REQ-031 Stream 0x1..0x8 back-to-back, out_ready=1 -> outputs 0x1..0x8 on 8 consecutive cycles, in_ready never 0.
REQ-032 Push 0x10, 0x11, 0x12 with out_ready=0 -> in_ready=0 after two accepts, occ=2, out_data=0x10 held; release out_ready -> 0x10, 0x11, 0x12 in order, none lost.
REQ-033 occ=2, flush=1 with in_valid=1, in_data=0x99, out_ready=0 -> next cycle occ=0, out_valid=0; 0x99 never appears at output.
REQ-034 Assert reset mid-stream with occ=2 -> next cycle occ=0, out_data=0, stall_cnt=0; traffic resumes correctly after reset release.
REQ-035 With PIPE_STALL_CNT_EN, hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; without macro stall_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Purpose : DEPTH-stage valid/ready register pipeline with collapsing bubbles, flush and occupancy count.
// Latency : DEPTH cycles from input transfer to out_valid when there is no backpressure; one transfer per cycle.
// Backpres: an empty stage always accepts, so stalls propagate upstream only through full stages; in_ready drops when stage 0 cannot move.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   reset      - synchronous active-low reset (priority over flush and handshakes)
//   flush      - invalidates every stage at the next edge; payload flops hold
//   in_valid / in_ready / in_data    - upstream handshake and payload
//   out_valid / out_ready / out_data - downstream handshake; payload comes straight from the last stage flops
//   occ        - registered count of valid stages (0..DEPTH)
//   stall_cnt  - saturating count of cycles with out_valid && !out_ready
//
// Optional feature: define PIPE_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt is tied to zero and no counter flops exist.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       occ,
  output logic [15:0]      stall_cnt
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [2:0]       occ_q;
  logic [2:0]       occ_d;

  // A stage loads when it is empty or when its content moves downstream.
  // Evaluated from the output end backwards so an empty stage anywhere
  // opens the path for everything upstream of it (bubble collapse).
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = !v_q[DEPTH-1] || out_ready;
    load[DEPTH-1] = nxt;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      nxt     = !v_q[i] || nxt;
      load[i] = nxt;
    end
  end

  assign in_ready = load[0] && !flush && reset;

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (flush) begin
      // Payload flops keep their contents; only the valid bits drop.
      v_d = '0;
    end else begin
      if (load[0]) begin
        v_d[0] = in_valid && in_ready;
        d_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          v_d[i] = v_q[i-1];
          d_d[i] = d_q[i-1];
        end
      end
    end
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + 3'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occ       = occ_q;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  // Flush does not clear the counter; only reset does.
  always_comb begin
    stall_d = stall_q;
    if (v_q[DEPTH-1] && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Purpose : directed self-checking bench for pipe_stage_buf (WIDTH=32, DEPTH=2).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpres: exercises stalls, flush and mid-stream reset with hand-computed expectations.
module tb_pipe_stage_buf;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  occ;
  logic [15:0] stall_cnt;

  int checks;
  int errors;

  pipe_stage_buf #(
    .WIDTH(32),
    .DEPTH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occ      (occ),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stall counter value: real count with the feature, else zero.
  function automatic logic [31:0] exp_stall(input int n);
`ifdef PIPE_STALL_CNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occ",       32'(occ),       32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_stall",     32'(stall_cnt), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);

    // Single word latency: accepted at cycle 0, visible at cycle 2
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0001;
    #1;
    check("lat_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("lat_c1_occ",   32'(occ),       32'd1);
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_c2_valid", 32'(out_valid), 32'd1);
    check("lat_c2_data",  out_data,       32'hA5A5_0001);
    check("lat_c2_occ",   32'(occ),       32'd1);
    tick();
    check("lat_c3_valid", 32'(out_valid), 32'd0);
    check("lat_c3_occ",   32'(occ),       32'd0);

    // Back-to-back stream 1..8 with no backpressure
    for (int n = 0; n < 11; n++) begin
      if (n >= 2 && n <= 9) begin
        check("strm_valid", 32'(out_valid), 32'd1);
        check("strm_data",  out_data,       32'(n - 1));
      end
      in_valid = (n < 8);
      in_data  = 32'(n + 1);
      #1;
      if (n < 8) check("strm_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("strm_drain_occ", 32'(occ), 32'd0);

    // Backpressure: two accepts fill the pipe, third word waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h10;
    #1;
    check("bp_rdy0", 32'(in_ready), 32'd1);
    tick();
    in_data = 32'h11;
    #1;
    check("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    in_data = 32'h12;
    #1;
    check("bp_full_rdy",  32'(in_ready),  32'd0);
    check("bp_full_occ",  32'(occ),       32'd2);
    check("bp_full_data", out_data,       32'h10);
    check("bp_full_vld",  32'(out_valid), 32'd1);
    tick();
    check("bp_hold_data", out_data,      32'h10);
    check("bp_hold_rdy",  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy",  32'(in_ready), 32'd1);
    check("bp_rel_data", out_data,      32'h10);
    tick();
    in_valid = 1'b0;
    check("bp_out1_vld",  32'(out_valid), 32'd1);
    check("bp_out1_data", out_data,       32'h11);
    tick();
    check("bp_out2_vld",  32'(out_valid), 32'd1);
    check("bp_out2_data", out_data,       32'h12);
    tick();
    check("bp_empty_occ", 32'(occ),       32'd0);
    check("bp_empty_vld", 32'(out_valid), 32'd0);

    // Flush with a full pipe and a word offered in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h20;
    tick();
    in_data = 32'h21;
    tick();
    check("fl_pre_occ", 32'(occ), 32'd2);
    flush   = 1'b1;
    in_data = 32'h99;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_occ",   32'(occ),       32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("fl_no_99_vld", 32'(out_valid), 32'd0);
      check("fl_no_99_occ", 32'(occ),       32'd0);
    end

    // Reset mid-stream with a full pipe
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h30;
    tick();
    in_data = 32'h31;
    tick();
    check("mr_pre_occ", 32'(occ), 32'd2);
    reset   = 1'b0;
    in_data = 32'h77;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("mr_occ",   32'(occ),       32'd0);
    check("mr_data",  out_data,       32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_stall", 32'(stall_cnt), 32'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h40;
    tick();
    in_valid = 1'b0;
    tick();
    check("mr_resume_vld",  32'(out_valid), 32'd1);
    check("mr_resume_data", out_data,       32'h40);
    tick();

    // Stall counter: clean start, then hold one word stalled for 5 edges
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h50;
    tick();
    in_valid = 1'b0;
    tick();
    check("st_vld",   32'(out_valid), 32'd1);
    check("st_start", 32'(stall_cnt), 32'd0);
    for (int n = 0; n < 5; n++) tick();
    check("st_five", 32'(stall_cnt), exp_stall(5));
    check("st_data", out_data,       32'h50);
    // The flush edge still sees a stalled output, then the pipe is empty
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("st_after_flush", 32'(stall_cnt), exp_stall(6));
    check("st_flush_vld",   32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
